// File: rtl/binary_codec_pkg.sv
// Shared definitions for the binary encoder/decoder family: code and one-hot
// widths, the decoder sequencer state type and the 2-to-4 decode helper.
package binary_codec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  // 2-bit binary code to one-hot word, code value selects the set bit.
  function automatic logic [ONEHOT_W-1:0] decode24(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] word;
    case (code)
      2'b00:   word = 4'b0001;
      2'b01:   word = 4'b0010;
      2'b10:   word = 4'b0100;
      2'b11:   word = 4'b1000;
      default: word = 4'b0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/binary_decoder24_seq_if.sv
// Handshake input and one-hot output bundle of binary_decoder24_seq.
// The slave modport is the decoder itself; master is the producer/consumer side.
interface binary_decoder24_seq_if;
  logic En;
  logic in_valid;
  logic in_ready;
  logic q1;
  logic q0;
  logic d3;
  logic d2;
  logic d1;
  logic d0;
  logic out_valid;
  logic busy;

  modport slave (
    input  En, in_valid, q1, q0,
    output in_ready, d3, d2, d1, d0, out_valid, busy
  );

  modport master (
    output En, in_valid, q1, q0,
    input  in_ready, d3, d2, d1, d0, out_valid, busy
  );
endinterface

// File: rtl/binary_decoder24_seq_fifo4.sv
// binary_fifo4: small synchronous FIFO of CODE_W-bit codes. Pointers wrap via
// a DEPTH-1 mask (DEPTH is a power of two); an occupancy counter one bit wider
// than the pointers gives full/empty. Push when full and pop when empty are ignored.
module binary_fifo4
  import binary_codec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};

  logic [CODE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == LVL_FULL);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array write; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r + PTR_ONE) & PTR_MASK;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r + PTR_ONE) & PTR_MASK;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/binary_decoder24_seq.sv
// binary_decoder24_seq: sequenced 2-to-4 decoder. Codes {q1,q0} are queued in
// binary_fifo4 and each is shown as a registered one-hot word for DWELL enabled
// cycles, followed by GAP all-zero cycles. En low freezes the sequencer and
// blanks the outputs. Optional macro BINARY_DECODER24_CNT_EN adds dec_count,
// a wrapping count of popped codes.
module binary_decoder24_seq
  import binary_codec_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  binary_decoder24_seq_if.slave  bus
`ifdef BINARY_DECODER24_CNT_EN
  ,
  output logic [7:0]             dec_count
`endif
);

  // Enum literals share names with the timing parameters, so states are
  // always written with the package scope below.
  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam bit         GAP_ON   = (GAP != 0);

  dec_state_t          state_r;
  logic [7:0]          cnt_r;
  logic [7:0]          gcnt_r;
  logic [ONEHOT_W-1:0] word_r;
  logic [ONEHOT_W-1:0] d_r;
  logic                out_valid_r;

  logic [CODE_W-1:0]   code_s;
  logic [CODE_W-1:0]   head_s;
  logic                full_s;
  logic                empty_s;
  logic                in_ready_s;
  logic                push_s;
  logic                pop_s;

  assign code_s     = {bus.q1, bus.q0};
  assign in_ready_s = !full_s && !rst;
  assign push_s     = bus.in_valid && in_ready_s;

  binary_fifo4 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (code_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Pop decision from pre-edge occupancy, so a same-edge push is never popped.
  always_comb begin
    pop_s = 1'b0;
    if (bus.En && !empty_s) begin
      case (state_r)
        binary_codec_pkg::IDLE:  pop_s = 1'b1;
        binary_codec_pkg::DWELL: pop_s = (cnt_r == 8'd0) && !GAP_ON;
        binary_codec_pkg::GAP:   pop_s = (gcnt_r == 8'd0);
        default:                 pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Sequencer: dwell/gap counting and registered one-hot outputs; En low
  // freezes state and counters while blanking the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= binary_codec_pkg::IDLE;
      cnt_r       <= 8'd0;
      gcnt_r      <= 8'd0;
      word_r      <= 4'b0000;
      d_r         <= 4'b0000;
      out_valid_r <= 1'b0;
    end else if (!bus.En) begin
      d_r         <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        binary_codec_pkg::IDLE: begin
          if (pop_s) begin
            word_r      <= decode24(head_s);
            d_r         <= decode24(head_s);
            out_valid_r <= 1'b1;
            cnt_r       <= DWELL_LD;
            state_r     <= binary_codec_pkg::DWELL;
          end else begin
            d_r         <= 4'b0000;
            out_valid_r <= 1'b0;
          end
        end
        binary_codec_pkg::DWELL: begin
          if (cnt_r != 8'd0) begin
            cnt_r       <= cnt_r - 8'd1;
            d_r         <= word_r;
            out_valid_r <= 1'b1;
          end else if (GAP_ON) begin
            d_r         <= 4'b0000;
            out_valid_r <= 1'b0;
            gcnt_r      <= GAP_LD;
            state_r     <= binary_codec_pkg::GAP;
          end else if (pop_s) begin
            word_r      <= decode24(head_s);
            d_r         <= decode24(head_s);
            out_valid_r <= 1'b1;
            cnt_r       <= DWELL_LD;
          end else begin
            d_r         <= 4'b0000;
            out_valid_r <= 1'b0;
            state_r     <= binary_codec_pkg::IDLE;
          end
        end
        binary_codec_pkg::GAP: begin
          if (gcnt_r != 8'd0) begin
            gcnt_r      <= gcnt_r - 8'd1;
            d_r         <= 4'b0000;
            out_valid_r <= 1'b0;
          end else if (pop_s) begin
            word_r      <= decode24(head_s);
            d_r         <= decode24(head_s);
            out_valid_r <= 1'b1;
            cnt_r       <= DWELL_LD;
            state_r     <= binary_codec_pkg::DWELL;
          end else begin
            d_r         <= 4'b0000;
            out_valid_r <= 1'b0;
            state_r     <= binary_codec_pkg::IDLE;
          end
        end
        default: begin
          d_r         <= 4'b0000;
          out_valid_r <= 1'b0;
          state_r     <= binary_codec_pkg::IDLE;
        end
      endcase
    end
  end

`ifdef BINARY_DECODER24_CNT_EN
  // Count of popped codes, wrapping 255 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count <= 8'd0;
    end else if (pop_s) begin
      dec_count <= dec_count + 8'd1;
    end else begin
      dec_count <= dec_count;
    end
  end
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.d3        = d_r[3];
  assign bus.d2        = d_r[2];
  assign bus.d1        = d_r[1];
  assign bus.d0        = d_r[0];
  assign bus.out_valid = out_valid_r;
  // Built only from registered state and registered occupancy.
  assign bus.busy      = (state_r != binary_codec_pkg::IDLE) || !empty_s;

endmodule
